// File: rtl/mul_batch_sequencer_if.sv
// mul_batch_sequencer_if
//   Groups the run handshake and the data-memory port used by mul_batch_sequencer.
//   master : the sequencer (drives the memory port, reports done/busy).
//   slave  : the host/memory side (drives start, returns read data).
//   Signals:
//     start     host -> seq   run request, a 1->0 transition launches a run
//     done      seq  -> host  results complete, held until start rises
//     busy      seq  -> host  sequencer is loading/multiplying/storing
//     mem_own   seq  -> mem   steers the data-memory port to the sequencer
//     mem_addr  seq  -> mem   byte address
//     mem_we    seq  -> mem   synchronous write enable
//     mem_wdata seq  -> mem   write byte
//     mem_rdata mem  -> seq   combinational read byte of mem_addr
interface mul_batch_sequencer_if #(
    parameter int unsigned AW = 8
);
    logic          start;
    logic          done;
    logic          busy;
    logic          mem_own;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    modport master (
        input  start,
        input  mem_rdata,
        output done,
        output busy,
        output mem_own,
        output mem_addr,
        output mem_we,
        output mem_wdata
    );

    modport slave (
        output start,
        output mem_rdata,
        input  done,
        input  busy,
        input  mem_own,
        input  mem_addr,
        input  mem_we,
        input  mem_wdata
    );
endinterface

// File: rtl/mul_batch_sequencer.sv
// mul_batch_sequencer
//   Runs NUM_PAIRS unsigned 16x16 multiplies out of data memory. Pair j is read
//   big-endian from SRC_BASE+4j..+3 (A then B) and the 32-bit product is written
//   big-endian to DST_BASE+4j..+3. Each pair takes 4 load + 16 shift-add + 4 store
//   cycles. The sequencer owns the memory port only while busy.
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset
//     bus      mul_batch_sequencer_if.master (handshake + memory port)
module mul_batch_sequencer #(
    parameter int unsigned NUM_PAIRS = 16,
    parameter int unsigned SRC_BASE  = 0,
    parameter int unsigned DST_BASE  = 64,
    parameter int unsigned AW        = 8
) (
    input logic                  clk,
    input logic                  reset_n,
    mul_batch_sequencer_if.master bus
);

    localparam int unsigned JW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
    localparam logic [JW-1:0] LastPair = JW'(NUM_PAIRS - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLoad  = 3'd1;
    localparam logic [2:0] StMul   = 3'd2;
    localparam logic [2:0] StStore = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    logic [2:0]    r_state, w_state_d;
    logic          r_start_q;
    logic [JW-1:0] r_j, w_j_d;
    logic [1:0]    r_byte, w_byte_d;
    logic [3:0]    r_i, w_i_d;
    logic [15:0]   r_op_a, w_op_a_d;
    logic [15:0]   r_op_b, w_op_b_d;
    logic [31:0]   r_prod, w_prod_d;

    logic          w_launch;
    logic          w_busy;
    logic [31:0]   w_addend;
    logic [AW-1:0] w_src_addr;
    logic [AW-1:0] w_dst_addr;
    logic [7:0]    w_store_byte;

    // Launch needs a high sample of start followed by a low one.
    assign w_launch = r_start_q & ~bus.start;
    assign w_addend = {16'h0000, r_op_a} << r_i;

    // {j, b} is exactly 4j+b; parameter legality keeps these from wrapping.
    assign w_src_addr = AW'(SRC_BASE) + AW'({r_j, r_byte});
    assign w_dst_addr = AW'(DST_BASE) + AW'({r_j, r_byte});

    always_comb begin
        w_store_byte = 8'h00;
        unique case (r_byte)
            2'd0: w_store_byte = r_prod[31:24];
            2'd1: w_store_byte = r_prod[23:16];
            2'd2: w_store_byte = r_prod[15:8];
            2'd3: w_store_byte = r_prod[7:0];
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        w_j_d     = r_j;
        w_byte_d  = r_byte;
        w_i_d     = r_i;
        w_op_a_d  = r_op_a;
        w_op_b_d  = r_op_b;
        w_prod_d  = r_prod;
        case (r_state)
            StIdle: begin
                if (w_launch) begin
                    w_state_d = StLoad;
                    w_j_d     = '0;
                    w_byte_d  = '0;
                end
            end
            StLoad: begin
                if (bus.start) begin
                    w_state_d = StIdle;
                end else begin
                    unique case (r_byte)
                        2'd0: w_op_a_d[15:8] = bus.mem_rdata;
                        2'd1: w_op_a_d[7:0]  = bus.mem_rdata;
                        2'd2: w_op_b_d[15:8] = bus.mem_rdata;
                        2'd3: w_op_b_d[7:0]  = bus.mem_rdata;
                    endcase
                    w_byte_d = r_byte + 2'd1;
                    if (r_byte == 2'd3) begin
                        w_prod_d  = '0;
                        w_i_d     = '0;
                        w_state_d = StMul;
                    end
                end
            end
            StMul: begin
                if (bus.start) begin
                    w_state_d = StIdle;
                end else begin
                    if (r_op_b[r_i]) begin
                        w_prod_d = r_prod + w_addend;
                    end
                    w_i_d = r_i + 4'd1;
                    if (r_i == 4'd15) begin
                        w_byte_d  = '0;
                        w_state_d = StStore;
                    end
                end
            end
            StStore: begin
                if (bus.start) begin
                    w_state_d = StIdle;
                end else begin
                    w_byte_d = r_byte + 2'd1;
                    if (r_byte == 2'd3) begin
                        if (r_j == LastPair) begin
                            w_state_d = StDone;
                        end else begin
                            w_j_d     = r_j + 1'b1;
                            w_state_d = StLoad;
                        end
                    end
                end
            end
            StDone: begin
                if (bus.start) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= StIdle;
            r_start_q <= 1'b0;
            r_j       <= '0;
            r_byte    <= '0;
            r_i       <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_prod    <= '0;
        end else begin
            r_state   <= w_state_d;
            r_start_q <= bus.start;
            r_j       <= w_j_d;
            r_byte    <= w_byte_d;
            r_i       <= w_i_d;
            r_op_a    <= w_op_a_d;
            r_op_b    <= w_op_b_d;
            r_prod    <= w_prod_d;
        end
    end

    assign w_busy      = (r_state == StLoad) || (r_state == StMul) || (r_state == StStore);
    assign bus.busy    = w_busy;
    assign bus.mem_own = w_busy;
    assign bus.done    = (r_state == StDone);
    // Decoded straight from state so reset removes the write strobe asynchronously.
    assign bus.mem_we  = (r_state == StStore);

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = 8'h00;
        case (r_state)
            StLoad: bus.mem_addr = w_src_addr;
            StStore: begin
                bus.mem_addr  = w_dst_addr;
                bus.mem_wdata = w_store_byte;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mul_batch_sequencer.sv
// Bench for mul_batch_sequencer: table of hand-computed operand/product vectors
// plus directed sequences for reset, abort and reset-during-store.
module tb_mul_batch_sequencer;

    localparam int unsigned NumPairs = 16;
    localparam int unsigned SrcBase  = 0;
    localparam int unsigned DstBase  = 64;
    localparam int unsigned Aw       = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    mul_batch_sequencer_if #(.AW(Aw)) bus ();

    mul_batch_sequencer #(
        .NUM_PAIRS(NumPairs),
        .SRC_BASE (SrcBase),
        .DST_BASE (DstBase),
        .AW       (Aw)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic       tb_we;
    logic [7:0] tb_addr;
    logic [7:0] tb_wdata;

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        else if (tb_we) mem[tb_addr] <= tb_wdata;
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t        vecs [NumPairs];
    logic [31:0] sb   [NumPairs];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; the byte lands at the following posedge.
    task automatic poke(input int addr, input logic [7:0] d);
        tb_addr  = addr[7:0];
        tb_wdata = d;
        tb_we    = 1'b1;
        @(negedge clk);
        tb_we    = 1'b0;
    endtask

    task automatic load_pair(input int j, input logic [15:0] a, input logic [15:0] b);
        poke(SrcBase + 4 * j + 0, a[15:8]);
        poke(SrcBase + 4 * j + 1, a[7:0]);
        poke(SrcBase + 4 * j + 2, b[15:8]);
        poke(SrcBase + 4 * j + 3, b[7:0]);
    endtask

    task automatic fill_dst(input logic [7:0] d);
        for (int k = 0; k < 4 * NumPairs; k++) poke(DstBase + k, d);
    endtask

    function automatic logic [31:0] get_prod(input int j);
        int base;
        base = DstBase + 4 * j;
        return {mem[base], mem[base + 1], mem[base + 2], mem[base + 3]};
    endfunction

    // Ends right after the launch edge.
    task automatic launch_only();
        bus.start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
    endtask

    // edges counts posedges after the launch edge until done is seen.
    task automatic run(output int edges, output int we_n);
        launch_only();
        edges = 0;
        we_n  = 0;
        forever begin
            @(negedge clk);
            if (bus.done) break;
            if (bus.mem_we) we_n++;
            if (edges >= 1000) break;
            @(posedge clk);
            edges++;
        end
    endtask

    task automatic release_done();
        bus.start = 1'b1;
        @(negedge clk);
        check("done_drops_on_start", bus.done, 1'b0);
        check("busy_after_done", bus.busy, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int edges;
        int we_n;
        int bad;
        int busy_seen;

        vecs[0]  = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[1]  = '{16'h0001, 16'h8000, 32'h00008000};
        vecs[2]  = '{16'h0003, 16'h0005, 32'h0000000F};
        vecs[3]  = '{16'h1234, 16'h5678, 32'h06260060};
        vecs[4]  = '{16'h0000, 16'hFFFF, 32'h00000000};
        vecs[5]  = '{16'h00FF, 16'h00FF, 32'h0000FE01};
        vecs[6]  = '{16'h0100, 16'h0100, 32'h00010000};
        vecs[7]  = '{16'h8000, 16'h8000, 32'h40000000};
        vecs[8]  = '{16'h0002, 16'h7FFF, 32'h0000FFFE};
        vecs[9]  = '{16'hFFFF, 16'h0001, 32'h0000FFFF};
        vecs[10] = '{16'h000A, 16'h000A, 32'h00000064};
        vecs[11] = '{16'h1000, 16'h0010, 32'h00010000};
        vecs[12] = '{16'h00FF, 16'h0100, 32'h0000FF00};
        vecs[13] = '{16'hFFFF, 16'h0002, 32'h0001FFFE};
        vecs[14] = '{16'h0010, 16'h0010, 32'h00000100};
        vecs[15] = '{16'h1234, 16'h5678, 32'h06260060};

        bus.start = 1'b0;
        tb_we     = 1'b0;
        tb_addr   = '0;
        tb_wdata  = '0;
        reset_n   = 1'b0;

        // Reset held with start toggling: every output stays low.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.start = ~bus.start;
            #1;
            check("reset_outputs",
                  {bus.done, bus.busy, bus.mem_own, bus.mem_we, bus.mem_wdata, bus.mem_addr},
                  32'h0);
        end

        // Release with start low: no launch.
        @(negedge clk);
        bus.start = 1'b0;
        reset_n   = 1'b1;
        busy_seen = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.busy || bus.mem_we || bus.done) busy_seen++;
        end
        check("idle_no_launch", busy_seen, 0);

        // Basic run: only pair 0 non-zero.
        for (int k = 0; k < 256; k++) poke(k, 8'h00);
        load_pair(0, 16'h0003, 16'h0005);
        run(edges, we_n);
        check("basic_done", bus.done, 1'b1);
        check("basic_latency", edges, 384);
        check("basic_we_cycles", we_n, 64);
        check("basic_prod0", get_prod(0), 32'h0000000F);
        bad = 0;
        for (int j = 1; j < NumPairs; j++) if (get_prod(j) != 32'h0) bad++;
        check("basic_other_zero", bad, 0);
        release_done();

        // Table vectors including the extremes.
        for (int j = 0; j < NumPairs; j++) load_pair(j, vecs[j].a, vecs[j].b);
        fill_dst(8'hEE);
        run(edges, we_n);
        check("table_latency", edges, 384);
        for (int j = 0; j < NumPairs; j++) check($sformatf("table_prod%0d", j), get_prod(j), vecs[j].p);
        check("table_byte124", {24'h0, mem[124]}, 32'h06);
        check("table_byte127", {24'h0, mem[127]}, 32'h60);
        release_done();

        // Ten random runs against a scoreboard.
        for (int r = 0; r < 10; r++) begin
            for (int j = 0; j < NumPairs; j++) begin
                logic [15:0] a;
                logic [15:0] b;
                a = 16'($urandom);
                b = 16'($urandom);
                sb[j] = {16'h0, a} * {16'h0, b};
                load_pair(j, a, b);
            end
            fill_dst(8'hEE);
            run(edges, we_n);
            check("rand_done", bus.done, 1'b1);
            for (int j = 0; j < NumPairs; j++)
                check($sformatf("rand%0d_prod%0d", r, j), get_prod(j), sb[j]);
            release_done();
        end

        // Abort during pair 5 MUL (pair 5 multiplies after edges 124..139).
        for (int j = 0; j < NumPairs; j++) load_pair(j, vecs[j].a, vecs[j].b);
        fill_dst(8'hA5);
        launch_only();
        repeat (130) @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", bus.busy, 1'b1);
        bus.start = 1'b1;
        @(negedge clk);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_own_done", {bus.mem_own, bus.done}, 2'b00);
        repeat (5) @(negedge clk);
        for (int j = 0; j < 5; j++) check($sformatf("abort_prod%0d", j), get_prod(j), vecs[j].p);
        bad = 0;
        for (int k = 84; k < 128; k++) if (mem[k] != 8'hA5) bad++;
        check("abort_untouched", bad, 0);
        run(edges, we_n);
        check("relaunch_latency", edges, 384);
        for (int j = 0; j < NumPairs; j++) check($sformatf("relaunch_prod%0d", j), get_prod(j), vecs[j].p);
        release_done();

        // Reset during pair 3 STORE, byte 1 (after edge 93).
        fill_dst(8'hA5);
        launch_only();
        repeat (93) @(posedge clk);
        #2;
        check("mid_store_addr", {bus.mem_we, bus.mem_addr}, {1'b1, 8'd77});
        reset_n = 1'b0;
        #1;
        check("reset_we_drop", bus.mem_we, 1'b0);
        check("reset_done_busy", {bus.done, bus.busy}, 2'b00);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        reset_n   = 1'b1;
        @(negedge clk);
        check("reset_byte76", {24'h0, mem[76]}, 32'h06);
        check("reset_byte78", {24'h0, mem[78]}, 32'hA5);
        check("reset_byte79", {24'h0, mem[79]}, 32'hA5);
        check("reset_prod2", get_prod(2), vecs[2].p);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mul_batch_sequencer.md
Name: mul_batch_sequencer

Overview:
- Hardware sequencer for the program-3 workload: 16 unsigned 16x16 multiplies read from data memory, with 32-bit products written back.
- Operand pair j is read big-endian from bytes SRC_BASE+4j..4j+3 (A = first halfword, B = second halfword). Product A*B is written big-endian to DST_BASE+4j..4j+3.
- Sits beside topLevel's data memory. It owns the memory port while busy and uses the same start/done handshake as the core.

Parameters:
- NUM_PAIRS, 16, number of operand pairs processed per run.
- SRC_BASE, 0, byte address of first operand.
- DST_BASE, 64, byte address of first product.
- AW, 8, memory byte-address width. Legal only if DST_BASE+4*NUM_PAIRS-1 < 2**AW and SRC_BASE+4*NUM_PAIRS-1 < 2**AW.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  run request. High = hold/idle; a 1->0 transition launches a run.
- done  out  1  high while results are complete; held until start rises.
- busy  out  1  high in LOAD/MUL/STORE.
- mem_own  out  1  equals busy; selects sequencer onto the data-memory port.
- mem_addr  out  AW  byte address.
- mem_we  out  1  write enable; write is synchronous.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte; combinational read of mem_addr in the same cycle.

Behaviour:
- Reset (async assert): state=IDLE, start_q=0, pair j=0, byte b=0, iteration i=0, A/B/P regs=0. All outputs 0.
- start_q is a registered copy of start. A launch requires start_q=1 and start=0 at an edge. Start low out of reset does not launch.
- IDLE: outputs 0. On launch edge: j=0, b=0, go to LOAD.
- LOAD (4 cycles):
  - mem_addr=SRC_BASE+4j+b; mem_rdata captured at the edge.
  - b=0 -> A[15:8], b=1 -> A[7:0], b=2 -> B[15:8], b=3 -> B[7:0].
  - After b=3: P=0, i=0, go to MUL.
- MUL (16 cycles, shift-add):
  - Iteration i: if B[i], P = P + (A << i). P is 32-bit; no overflow is possible (max 0xFFFE0001).
  - After i=15: b=0, go to STORE.
- STORE (4 cycles):
  - mem_we=1, mem_addr=DST_BASE+4j+b, mem_wdata=P[31-8b -: 8] (MSB first).
  - After b=3: if j==NUM_PAIRS-1 go to DONE, else j++, b=0, go to LOAD.
- DONE: done=1, mem_own=0, mem_we=0. When start=1 is sampled, go to IDLE (done falls that edge).
- Latency: 24 cycles per pair. DONE is entered exactly 24*NUM_PAIRS = 384 edges after the launch edge.
- Abort: start=1 sampled in LOAD/MUL/STORE -> IDLE next edge. No further writes; products already written remain.
- A falling start while in DONE or IDLE without a prior high sample does not launch.
- mem_we is never asserted outside STORE. Addresses never wrap, by the parameter legality rule.
- Reset mid-run: immediate IDLE, mem_we drops asynchronously; memory contents untouched.

Test Plan:
- Reset then idle:
  - reset_n low with start toggling -> all outputs 0.
  - Release with start=0 -> no run, busy stays 0 for 50 cycles.
- Basic run:
  - Memory bytes 0..3 = 00 03 00 05, other operands 0.
  - Start 1->0 -> bytes 64..67 = 00 00 00 0F, all other products 0.
  - done rises exactly 384 edges after the launch edge; mem_we high for exactly 64 cycles total.
- Extremes:
  - Pair0 = FFFF*FFFF -> bytes 64..67 = FF FE 00 01.
  - Pair1 = 0001*8000 -> 00 00 80 00.
  - Pair15 = 1234*5678 -> 06 26 00 60 at bytes 124..127.
- Random ten runs:
  - Random 32 halfwords each run, start pulsed 1->0 -> all 16 products match A*B in the scoreboard.
  - done drops on start high each run.
- Abort:
  - Raise start during pair 5 MUL -> IDLE next edge, busy=0.
  - Pairs 0-4 are written, bytes 84..127 unchanged.
  - Relaunch completes normally.
- Reset mid-STORE:
  - reset_n low during pair 3 STORE b=1 -> mem_we drops immediately, done=0.
  - Bytes 78..79 are not written.
